// File: rtl/conv_window_fetch.sv
// Window fetch engine: streams every KxK window of a signed IMG_W x IMG_W image
// from a single-port RAM, re-using overlapping columns along each output row.
module conv_window_fetch #(
  parameter int IMG_W = 8,
  parameter int K     = 3,
  parameter int DW    = 8,
  parameter int AW    = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_st,
  output logic              busy,
  output logic              ram_rd_en,
  output logic [AW-1:0]     ram_addr,
  input  logic [DW-1:0]     ram_dout,
  output logic              win_valid,
  input  logic              win_ready,
  output logic [K*K*DW-1:0] win_data,
  output logic [2:0]        win_row,
  output logic [2:0]        win_col,
  output logic              done
);

  localparam int NPIX = K * K;
  localparam int CW   = $clog2(NPIX + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FILL  = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [CW-1:0] FILL_END  = CW'(NPIX);
  localparam logic [CW-1:0] SHIFT_END = CW'(K);
  localparam logic [2:0]    POS_LAST  = 3'(IMG_W - K);

  logic [2:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           row_q, row_d;
  logic [2:0]           col_q, col_d;
  logic signed [DW-1:0] win_q [NPIX];
  logic signed [DW-1:0] win_d [NPIX];

  logic                 rd_en;
  logic [AW-1:0]        rd_addr;
  int                   cnt_i;
  int                   rd_dr;
  int                   rd_dc;
  int                   cap_slot;

  // cnt_q counts issue slots; the datum for read n is captured when cnt_q = n+1
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    row_d    = row_q;
    col_d    = col_q;
    for (int k = 0; k < NPIX; k++) win_d[k] = win_q[k];
    rd_en    = 1'b0;
    rd_dr    = 0;
    rd_dc    = 0;
    cap_slot = 0;
    cnt_i    = int'(cnt_q);

    case (state_q)
      S_IDLE: begin
        if (in_st) begin
          row_d   = '0;
          col_d   = '0;
          cnt_d   = '0;
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        if (cnt_q != FILL_END) begin
          rd_en = 1'b1;
          rd_dr = cnt_i % K;
          rd_dc = cnt_i / K;
        end
        if (cnt_q != '0) begin
          cap_slot        = ((cnt_i - 1) % K) * K + (cnt_i - 1) / K;
          win_d[cap_slot] = $signed(ram_dout);
        end
        if (cnt_q == FILL_END) begin
          cnt_d   = '0;
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SHIFT: begin
        if (cnt_q != SHIFT_END) begin
          rd_en = 1'b1;
          rd_dr = cnt_i;
          rd_dc = K - 1;
        end
        if (cnt_q != '0) begin
          cap_slot        = (cnt_i - 1) * K + (K - 1);
          win_d[cap_slot] = $signed(ram_dout);
        end
        if (cnt_q == SHIFT_END) begin
          cnt_d   = '0;
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (win_ready) begin
          cnt_d = '0;
          if (col_q != POS_LAST) begin
            col_d   = col_q + 3'd1;
            state_d = S_SHIFT;
            // Slide left now so SHIFT only has to land the new right column
            for (int r = 0; r < K; r++)
              for (int c = 0; c < K - 1; c++)
                win_d[r*K + c] = win_q[r*K + c + 1];
          end else if (row_q != POS_LAST) begin
            col_d   = '0;
            row_d   = row_q + 3'd1;
            state_d = S_FILL;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    rd_addr = rd_en ? AW'((int'(row_q) + rd_dr) * IMG_W + int'(col_q) + rd_dc) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      for (int k = 0; k < NPIX; k++) win_q[k] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      col_q   <= col_d;
      for (int k = 0; k < NPIX; k++) win_q[k] <= win_d[k];
    end
  end

  assign busy      = (state_q == S_FILL) || (state_q == S_SHIFT) || (state_q == S_HOLD);
  assign done      = (state_q == S_DONE);
  assign win_valid = (state_q == S_HOLD);
  assign ram_rd_en = rd_en;
  assign ram_addr  = rd_addr;
  assign win_row   = row_q;
  assign win_col   = col_q;

  for (genvar k = 0; k < NPIX; k++) begin : g_pack
    assign win_data[k*DW +: DW] = win_q[k];
  end

endmodule

// File: tb/tb_conv_window_fetch.sv
// Directed bench for conv_window_fetch: ramp/signed images, backpressure,
// row wrap, ignored mid-frame start, rerun and mid-frame reset.
module tb_conv_window_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_st;
  logic        busy;
  logic        ram_rd_en;
  logic [5:0]  ram_addr;
  logic [7:0]  ram_dout;
  logic        win_valid;
  logic        win_ready;
  logic [71:0] win_data;
  logic [2:0]  win_row;
  logic [2:0]  win_col;
  logic        done;

  conv_window_fetch #(.IMG_W(8), .K(3), .DW(8), .AW(6)) dut (
    .clk(clk), .rst(rst), .in_st(in_st), .busy(busy),
    .ram_rd_en(ram_rd_en), .ram_addr(ram_addr), .ram_dout(ram_dout),
    .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
    .win_row(win_row), .win_col(win_col), .done(done)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [64];
  always @(posedge clk) if (ram_rd_en) ram_dout <= mem[ram_addr];

  int          tests = 0;
  int          fails = 0;
  logic        log_rd   [512];
  logic [5:0]  log_addr [512];
  logic        log_vld  [512];
  logic [71:0] wins     [36];
  logic [71:0] wins_ref [36];
  int          h05;

  localparam logic [71:0] W00_RAMP = 72'h12_11_10_0A_09_08_02_01_00;
  localparam logic [71:0] W55_RAMP = 72'h3F_3E_3D_37_36_35_2F_2E_2D;
  localparam logic [71:0] W23_RAMP = 72'h25_24_23_1D_1C_1B_15_14_13;
  localparam logic [71:0] W24_RAMP = 72'h26_25_24_1E_1D_1C_16_15_14;
  localparam logic [71:0] W00_SGN  = 72'h12_11_10_0A_09_08_02_01_FF;
  localparam logic [71:0] W55_SGN  = 72'h80_3E_3D_37_36_35_2F_2E_2D;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [71:0] exp_win(input int row, input int col);
    logic [71:0] w;
    w = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w[(3*r + c)*8 +: 8] = mem[(row + r)*8 + col + c];
    return w;
  endfunction

  function automatic int model_errors();
    int n;
    n = 0;
    for (int i = 0; i < 36; i++)
      if (wins[i] !== exp_win(i / 6, i % 6)) n++;
    return n;
  endfunction

  function automatic int ref_errors();
    int n;
    n = 0;
    for (int i = 0; i < 36; i++)
      if (wins[i] !== wins_ref[i]) n++;
    return n;
  endfunction

  task automatic fill_ramp();
    for (int i = 0; i < 64; i++) mem[i] = 8'(i);
  endtask

  // Start a frame at cycle 0; t counts cycles after the start cycle.
  task automatic run_frame(input int stall_r, input int stall_c, input bit pulse_mid,
                           output int first_vld, output int done_cyc, output int nreads,
                           output int nwin, output int bad);
    int          stall_left;
    bit          stalled;
    logic [71:0] snap_d;
    logic [5:0]  snap_rc;
    first_vld = -1; done_cyc = -1; nreads = 0; nwin = 0; bad = 0;
    stall_left = 0; stalled = 0; snap_d = '0; snap_rc = '0;
    in_st = 1'b1; win_ready = 1'b1;
    step();
    in_st = 1'b0;
    for (int t = 1; t < 400 && done_cyc < 0; t++) begin
      log_rd[t] = ram_rd_en; log_addr[t] = ram_addr; log_vld[t] = win_valid;
      if (ram_rd_en) nreads++;
      if (!ram_rd_en && ram_addr != 6'd0) bad++;
      if (done) begin
        done_cyc = t;
        if (busy) bad++;
      end
      if (win_valid && first_vld < 0) first_vld = t;
      in_st = (pulse_mid && t == 50);
      win_ready = 1'b1;
      if (stall_left > 0) begin
        win_ready = 1'b0;
        stall_left--;
        if (win_data !== snap_d || {win_row, win_col} !== snap_rc || ram_rd_en || !win_valid) bad++;
      end else if (win_valid && !stalled && int'(win_row) == stall_r && int'(win_col) == stall_c) begin
        stalled = 1; stall_left = 4; win_ready = 1'b0;
        snap_d = win_data; snap_rc = {win_row, win_col};
      end
      if (win_valid && win_ready) begin
        wins[int'(win_row)*6 + int'(win_col)] = win_data;
        nwin++;
        if (win_row == 3'd0 && win_col == 3'd5) h05 = t;
      end
      step();
    end
    in_st = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int fv, dc, nr, nw, bad;
    int wait_ok;
    logic [5:0] wrap_addr [9];
    wrap_addr = '{6'd8, 6'd16, 6'd24, 6'd9, 6'd17, 6'd25, 6'd10, 6'd18, 6'd26};
    h05 = -1;
    rst = 1'b1; in_st = 1'b0; win_ready = 1'b0;
    fill_ramp();
    step(); step(); step();
    check("rst_busy", busy, 0);
    check("rst_rd_en", ram_rd_en, 0);
    check("rst_addr", ram_addr, 0);
    check("rst_valid", win_valid, 0);
    check("rst_data", win_data, 0);
    check("rst_rowcol", {win_row, win_col}, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    step();

    // Ramp frame, ready tied high, spurious start at cycle 50
    run_frame(-1, -1, 1'b1, fv, dc, nr, nw, bad);
    check("A_first_valid", fv, 11);
    check("A_done_cycle", dc, 217);
    check("A_reads", nr, 144);
    check("A_windows", nw, 36);
    check("A_protocol", bad, 0);
    check("A_done_pulse_len", done, 0);
    check("A_w00", wins[0], W00_RAMP);
    check("A_w55", wins[35], W55_RAMP);
    check("A_model", model_errors(), 0);
    check("A_h05", h05, 36);
    for (int i = 0; i < 9; i++) begin
      check("wrap_rd_en", log_rd[h05 + 1 + i], 1);
      check("wrap_addr", log_addr[h05 + 1 + i], wrap_addr[i]);
    end
    check("wrap_no_10th_read", log_rd[h05 + 10], 0);
    check("wrap_vld_low", log_vld[h05 + 10], 0);
    check("wrap_vld_high", log_vld[h05 + 11], 1);
    check("shift_vld_low", log_vld[h05 - 1], 0);
    for (int i = 0; i < 36; i++) wins_ref[i] = wins[i];

    // Rerun right after done, 5-cycle stall on window (2,3)
    run_frame(2, 3, 1'b0, fv, dc, nr, nw, bad);
    check("B_first_valid", fv, 11);
    check("B_done_cycle", dc, 222);
    check("B_reads", nr, 144);
    check("B_stall_stable", bad, 0);
    check("B_w23", wins[15], W23_RAMP);
    check("B_w24", wins[16], W24_RAMP);
    check("B_same_as_A", ref_errors(), 0);

    // Signed extremes at corners
    mem[0] = 8'hFF; mem[63] = 8'h80;
    run_frame(-1, -1, 1'b0, fv, dc, nr, nw, bad);
    check("C_done_cycle", dc, 217);
    check("C_p0", wins[0][7:0], 8'hFF);
    check("C_p8", wins[35][71:64], 8'h80);
    check("C_w00", wins[0], W00_SGN);
    check("C_w55", wins[35], W55_SGN);
    check("C_model", model_errors(), 0);
    fill_ramp();

    // Reset while window (3,2) is held
    in_st = 1'b1; win_ready = 1'b1;
    step();
    in_st = 1'b0;
    wait_ok = 0;
    for (int t = 0; t < 300 && wait_ok == 0; t++) begin
      if (win_valid && win_row == 3'd3 && win_col == 3'd2) begin
        win_ready = 1'b0;
        wait_ok = 1;
      end else begin
        step();
      end
    end
    check("D_reach_w32", wait_ok, 1);
    check("D_w32", win_data, exp_win(3, 2));
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("D_rst_busy", busy, 0);
    check("D_rst_valid", win_valid, 0);
    check("D_rst_data", win_data, 0);
    check("D_rst_rowcol", {win_row, win_col}, 0);
    check("D_rst_rd", {ram_rd_en, ram_addr}, 0);
    check("D_rst_done", done, 0);
    bad = 0;
    win_ready = 1'b1;
    for (int t = 0; t < 20; t++) begin
      if (done || busy || win_valid) bad++;
      step();
    end
    check("D_quiet_after_rst", bad, 0);
    in_st = 1'b1;
    step();
    in_st = 1'b0;
    for (int t = 1; t < 10; t++) step();
    check("D_vld_T10", win_valid, 0);
    step();
    check("D_vld_T11", win_valid, 1);
    check("D_restart_w00", win_data, W00_RAMP);
    check("D_restart_rowcol", {win_row, win_col}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
